key_word_reg_file: RTL and testbench

Parametrised word register file for the KeyExpansion datapath. It holds expanded round-key words: 44 words of 32 bits for AES-128 by default. Storage is written through an internal one-hot write decoder of width 2^ADDR_W. Writes use either an explicit address or an auto-incrementing fill pointer. Two independent registered read ports serve the round-key consumers, and per-word valid tracking and fill status go to the key-expansion controller.

---
 rtl/key_word_reg_file.sv | 179 +++++++++++++++++
 tb/tb_key_word_reg_file.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/key_word_reg_file.sv
// key_word_reg_file
// ------------------------------------------------------------------
// Word register file for the KeyExpansion datapath. It stores the expanded
// round-key words (44 x 32 bits for AES-128 by default). Each word has a
// valid bit. Writes go to an explicit address or to an auto-incrementing
// fill pointer. Two independent read ports each return registered data
// one cycle after the request.
//
// Optional feature macro: KEY_RF_READ_BYPASS_EN
//   When defined, a read of the address being written in the same cycle
//   returns the incoming write data with valid = 1 (per port, suppressed by
//   clr). When undefined, such a read returns the old word and old valid bit.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   clr                   soft clear of valid bits and fill pointer (data kept)
//   wr_en, wr_auto        write request; 1 = write at fill pointer, 0 = at wr_addr
//   wr_addr, wr_data      explicit write address, write data
//   rd_en_a, rd_addr_a    port A request and address
//   rd_data_a, rd_valid_a port A registered data and valid
//   rd_en_b, rd_addr_b    port B request and address
//   rd_data_b, rd_valid_b port B registered data and valid
//   wr_ptr                fill pointer (low ADDR_W bits)
//   full                  fill pointer has reached DEPTH
//   wr_err                one-cycle pulse after a rejected write
// ------------------------------------------------------------------
module key_word_reg_file #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 44
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic              wr_auto,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_valid_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid_b,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              full,
  output logic              wr_err
);

  localparam int NWORDS = 2 ** ADDR_W;
  // One extra bit so the pointer can hold DEPTH even when DEPTH == 2^ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic              wr_err_q, wr_err_d;

  logic [ADDR_W:0]   eff_addr;
  logic [NWORDS-1:0] wr_sel;
  logic              wr_hit, wr_accept;

  // Full address space views; unimplemented words read as zero / invalid.
  logic [DATA_W-1:0] word_ext [NWORDS];
  logic [NWORDS-1:0] valid_ext;

  logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
  logic              rd_valid_a_q, rd_valid_a_d, rd_valid_b_q, rd_valid_b_d;

  // A full pointer equals DEPTH, which matches no implemented word. The
  // decoder therefore rejects auto writes while full by itself.
  assign eff_addr = wr_auto ? ptr_q : {1'b0, wr_addr};

  generate
    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
      if (gi < DEPTH) begin : g_impl
        assign wr_sel[gi]    = wr_en && (eff_addr == (ADDR_W + 1)'(gi));
        assign word_ext[gi]  = mem_q[gi];
        assign valid_ext[gi] = valid_q[gi];
      end else begin : g_unimpl
        assign wr_sel[gi]    = 1'b0;
        assign word_ext[gi]  = '0;
        assign valid_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign wr_hit    = |wr_sel;
  assign wr_accept = wr_hit && !clr;
  // clr drops a same-cycle write silently, so it does not count as a rejection.
  assign wr_err_d  = wr_en && !wr_hit && !clr;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (wr_accept && wr_auto) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i]   <= '0;
        valid_q[i] <= 1'b0;
      end
      ptr_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr) begin
          valid_q[i] <= 1'b0;
        end else if (wr_sel[i]) begin
          mem_q[i]   <= wr_data;
          valid_q[i] <= 1'b1;
        end
      end
      ptr_q    <= ptr_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Port A next state: data holds when idle, valid only follows a request.
  always_comb begin
    rd_data_a_d  = rd_data_a_q;
    rd_valid_a_d = 1'b0;
    if (rd_en_a) begin
      rd_data_a_d  = word_ext[rd_addr_a];
      rd_valid_a_d = valid_ext[rd_addr_a];
`ifdef KEY_RF_READ_BYPASS_EN
      if (wr_accept && (eff_addr == {1'b0, rd_addr_a})) begin
        rd_data_a_d  = wr_data;
        rd_valid_a_d = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    rd_data_b_d  = rd_data_b_q;
    rd_valid_b_d = 1'b0;
    if (rd_en_b) begin
      rd_data_b_d  = word_ext[rd_addr_b];
      rd_valid_b_d = valid_ext[rd_addr_b];
`ifdef KEY_RF_READ_BYPASS_EN
      if (wr_accept && (eff_addr == {1'b0, rd_addr_b})) begin
        rd_data_b_d  = wr_data;
        rd_valid_b_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_a_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_data_b_q  <= '0;
      rd_valid_b_q <= 1'b0;
    end else begin
      rd_data_a_q  <= rd_data_a_d;
      rd_valid_a_q <= rd_valid_a_d;
      rd_data_b_q  <= rd_data_b_d;
      rd_valid_b_q <= rd_valid_b_d;
    end
  end

  assign rd_data_a  = rd_data_a_q;
  assign rd_valid_a = rd_valid_a_q;
  assign rd_data_b  = rd_data_b_q;
  assign rd_valid_b = rd_valid_b_q;
  assign wr_ptr     = ptr_q[ADDR_W-1:0];
  assign full       = (ptr_q == DEPTH_P);
  assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_key_word_reg_file.sv
// Testbench for key_word_reg_file. The stimulus pushes expected read results
// into per-port queues. A monitor pops an entry one cycle after each request
// and compares it. Status outputs are checked directly after each edge.
module tb_key_word_reg_file;

  logic        clk = 1'b0;
  logic        rst, clr, wr_en, wr_auto;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en_a, rd_en_b;
  logic [5:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b;
  logic [5:0]  wr_ptr;
  logic        full, wr_err;

  key_word_reg_file dut (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_en(wr_en), .wr_auto(wr_auto), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
    .wr_ptr(wr_ptr), .full(full), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        v;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic pend_a  = 1'b0;
  logic pend_b  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic exp_a(input logic [31:0] d, input logic v);
    exp_t e;
    e.d = d; e.v = v;
    qa.push_back(e);
  endtask

  task automatic exp_b(input logic [31:0] d, input logic v);
    exp_t e;
    e.d = d; e.v = v;
    qb.push_back(e);
  endtask

  task automatic idle();
    rst = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_auto = 1'b0;
    wr_addr = '0; wr_data = '0;
    rd_en_a = 1'b0; rd_addr_a = '0; rd_en_b = 1'b0; rd_addr_b = '0;
  endtask

  // One clock cycle with the given inputs, then back to idle just after the edge.
  task automatic step(input logic we, input logic au, input logic [5:0] wa, input logic [31:0] wd,
                      input logic ea, input logic [5:0] aa, input logic eb, input logic [5:0] ab,
                      input logic c, input logic r);
    wr_en = we; wr_auto = au; wr_addr = wa; wr_data = wd;
    rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
    clr = c; rst = r;
    @(posedge clk);
    #1;
    idle();
  endtask

  // Monitor: remembers which ports issued a read and compares them on the following falling edge.
  always @(posedge clk) begin
    pend_a <= rd_en_a;
    pend_b <= rd_en_b;
  end

  always @(negedge clk) begin
    exp_t e;
    if (pend_a) begin
      if (qa.size() == 0) begin
        n_total++;
        $display("FAIL rd_a_unexpected: got 0x%08h/%0b expected no pending read", rd_data_a, rd_valid_a);
      end else begin
        e = qa.pop_front();
        chk("rd_data_a", rd_data_a, e.d);
        chk("rd_valid_a", 32'(rd_valid_a), 32'(e.v));
      end
    end
    if (pend_b) begin
      if (qb.size() == 0) begin
        n_total++;
        $display("FAIL rd_b_unexpected: got 0x%08h/%0b expected no pending read", rd_data_b, rd_valid_b);
      end else begin
        e = qb.pop_front();
        chk("rd_data_b", rd_data_b, e.d);
        chk("rd_valid_b", 32'(rd_valid_b), 32'(e.v));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    chk("rst_rd_valid_a", 32'(rd_valid_a), 32'd0);
    chk("rst_rd_valid_b", 32'(rd_valid_b), 32'd0);
    chk("rst_rd_data_a", rd_data_a, 32'd0);

    // Fill all 44 words with auto writes.
    for (int i = 0; i < 44; i++) begin
      chk("fill_wr_ptr", 32'(wr_ptr), 32'(i));
      chk("fill_full", 32'(full), 32'd0);
      step(1'b1, 1'b1, 6'd0, 32'h1000 + 32'(i), 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    end
    chk("filled_wr_ptr", 32'(wr_ptr), 32'd44);
    chk("filled_full", 32'(full), 32'd1);
    chk("filled_wr_err", 32'(wr_err), 32'd0);
    exp_a(32'h0000102B, 1'b1);
    step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 6'd43, 1'b0, 6'd0, 1'b0, 1'b0);

    // Auto write while full is rejected.
    step(1'b1, 1'b1, 6'd0, 32'hDEADBEEF, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("full_wr_err", 32'(wr_err), 32'd1);
    chk("full_wr_ptr", 32'(wr_ptr), 32'd44);
    chk("full_full", 32'(full), 32'd1);
    step(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("wr_err_one_cycle", 32'(wr_err), 32'd0);
    for (int i = 0; i < 44; i++) begin
      exp_a(32'h1000 + 32'(i), 1'b1);
      exp_b(32'h1000 + 32'(43 - i), 1'b1);
      step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 6'(i), 1'b1, 6'(43 - i), 1'b0, 1'b0);
    end

    // Explicit write beyond DEPTH and a legal explicit overwrite.
    step(1'b1, 1'b0, 6'd50, 32'h55555555, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("oor_wr_err", 32'(wr_err), 32'd1);
    chk("oor_wr_ptr", 32'(wr_ptr), 32'd44);
    exp_b(32'd0, 1'b0);
    step(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 1'b1, 6'd50, 1'b0, 1'b0);
    chk("oor_wr_err_clear", 32'(wr_err), 32'd0);
    step(1'b1, 1'b0, 6'd7, 32'hA5A5A5A5, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("expl_wr_err", 32'(wr_err), 32'd0);
    chk("expl_wr_ptr", 32'(wr_ptr), 32'd44);
    exp_a(32'hA5A5A5A5, 1'b1);
    step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 6'd7, 1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("hold_rd_data_a", rd_data_a, 32'hA5A5A5A5);
    chk("hold_rd_valid_a", 32'(rd_valid_a), 32'd0);

    // clr, refill 4 words, then clr with a write and a read in the same cycle.
    step(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 1'b0);
    chk("clr_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("clr_full", 32'(full), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 6'd0, 32'h2000 + 32'(i), 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    end
    chk("refill_wr_ptr", 32'(wr_ptr), 32'd4);
    exp_a(32'h00002001, 1'b1);
    step(1'b1, 1'b1, 6'd0, 32'hFFFF0000, 1'b1, 6'd1, 1'b0, 6'd0, 1'b1, 1'b0);
    chk("clrwr_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("clrwr_wr_err", 32'(wr_err), 32'd0);
    exp_a(32'h00002002, 1'b0);
    exp_b(32'h00001004, 1'b0);
    step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 6'd2, 1'b1, 6'd4, 1'b0, 1'b0);

    // Reset mid-fill with reads in flight on both ports.
    step(1'b1, 1'b1, 6'd0, 32'hCAFE0000, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 6'd0, 32'hCAFE0001, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 6'd10, 32'hCAFE0010, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("prerst_wr_ptr", 32'(wr_ptr), 32'd2);
    exp_a(32'd0, 1'b0);
    exp_b(32'd0, 1'b0);
    step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 6'd10, 1'b1, 6'd10, 1'b0, 1'b1);
    chk("midrst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("midrst_full", 32'(full), 32'd0);
    chk("midrst_wr_err", 32'(wr_err), 32'd0);
    for (int i = 0; i < 44; i++) begin
      exp_a(32'd0, 1'b0);
      exp_b(32'd0, 1'b0);
      step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 6'(i), 1'b1, 6'(i), 1'b0, 1'b0);
    end

    // Same-cycle write and read of address 5 (old value 0 after reset).
`ifdef KEY_RF_READ_BYPASS_EN
    exp_a(32'h12345678, 1'b1);
`else
    exp_a(32'd0, 1'b0);
`endif
    step(1'b1, 1'b0, 6'd5, 32'h12345678, 1'b1, 6'd5, 1'b0, 6'd0, 1'b0, 1'b0);
    exp_a(32'h12345678, 1'b1);
    exp_b(32'h12345678, 1'b1);
    step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 6'd5, 1'b1, 6'd5, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d/%0d pending reads expected 0/0", qa.size(), qb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
